// File: rtl/div_pkg.sv
// Shared encodings for the divider scheduler: op codes, FSM states and op decode helpers.
package div_pkg;

    localparam logic [1:0] OP_DIVU = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, busy for WIDTH cycles after launch.
module Divider #(
    parameter int WIDTH = 32,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             launch,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    // Shift the next dividend bit into the partial remainder, subtract if it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, dsr_q};
        step_rem = shifted[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            step_rem = diff[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else if (launch) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(WIDTH);
            rem_q  <= '0;
            quo_q  <= dividend;
            dsr_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy        = busy_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = (dsr_q == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    logic [IDW:0] pos;

    // Scan from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (pos >= (IDW + 1)'(NREQ)) begin
                pos = pos - (IDW + 1)'(NREQ);
            end
            if (req_valid[pos[IDW-1:0]]) begin
                grant_idx   = pos[IDW-1:0];
                grant_valid = 1'b1;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one unsigned Divider between NREQ requesters with round-robin grant, RV32M sign
// handling, divide-by-zero bypass and a tagged response. Handshakes: a transfer happens on
// a rising edge where valid && ready; req_ready is only ever raised in IDLE for the grantee.
module div_scheduler
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    input  logic [2*NREQ-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [1:0]            state_dbg
);

    div_state_e       state_q, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_valid;

    logic [WIDTH-1:0] sel_dvd, sel_dsr;
    logic [1:0]       sel_op;
    logic             dvd_neg, dsr_neg, sel_dsr_zero;
    logic [WIDTH-1:0] abs_dvd, abs_dsr, bypass_data;
    logic [IDW-1:0]   next_ptr;

    logic             accept, capture, core_launch;
    logic             core_busy, core_dbz;
    logic [WIDTH-1:0] core_quo, core_rem;

    logic             is_rem_q, quo_neg_q, rem_neg_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] dvd_q, dsr_q, rsp_data_q;
    logic [WIDTH-1:0] core_res, fixed_res;
    logic             res_neg;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_dvd = '0;
        sel_dsr = '0;
        sel_op  = OP_DIVU;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_dvd = req_dividend[i*WIDTH +: WIDTH];
                sel_dsr = req_divisor[i*WIDTH +: WIDTH];
                sel_op  = req_op[2*i +: 2];
            end
        end
    end

    // The most-negative value negates to itself, which read unsigned is its true magnitude.
    assign dvd_neg      = op_is_signed(sel_op) & sel_dvd[WIDTH-1];
    assign dsr_neg      = op_is_signed(sel_op) & sel_dsr[WIDTH-1];
    assign abs_dvd      = dvd_neg ? -sel_dvd : sel_dvd;
    assign abs_dsr      = dsr_neg ? -sel_dsr : sel_dsr;
    assign sel_dsr_zero = (sel_dsr == '0);
    assign bypass_data  = op_is_rem(sel_op) ? sel_dvd : '1;
    assign next_ptr     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        accept      = 1'b0;
        capture     = 1'b0;
        core_launch = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_d   = sel_dsr_zero ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                core_launch = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (!core_busy) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    Divider #(.WIDTH(WIDTH)) u_divider (
        .clk         (clk),
        .reset       (reset),
        .launch      (core_launch),
        .dividend    (dvd_q),
        .divisor     (dsr_q),
        .busy        (core_busy),
        .quotient    (core_quo),
        .remainder   (core_rem),
        .div_by_zero (core_dbz)
    );

    assign core_res  = is_rem_q ? core_rem : core_quo;
    assign res_neg   = is_rem_q ? rem_neg_q : quo_neg_q;
    assign fixed_res = res_neg ? -core_res : core_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            is_rem_q   <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            id_q       <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                rr_ptr    <= next_ptr;
                is_rem_q  <= op_is_rem(sel_op);
                quo_neg_q <= dvd_neg ^ dsr_neg;
                rem_neg_q <= dvd_neg;
                id_q      <= grant_idx;
                dvd_q     <= abs_dvd;
                dsr_q     <= abs_dsr;
                if (sel_dsr_zero) begin
                    rsp_data_q <= bypass_data;
                end
            end
            if (capture) begin
                rsp_data_q <= fixed_res;
            end
        end
    end

    // The zero-divisor bypass means the core never works on a zero divisor.
    always_ff @(posedge clk) begin
        if (state_q == ST_WAIT) begin
            assert (!core_dbz);
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign state_dbg = state_q;

endmodule
